// File: rtl/centroid_tracker_if.sv
// Pixel-stream and centroid-result bundle between the filter stage, the
// centroid tracker and the lightboard drawing logic.
interface centroid_tracker_if;
  logic        data_valid_in;
  logic [15:0] pixel_data_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [4:0]  thresh_r_in;
  logic [5:0]  thresh_g_in;
  logic [4:0]  thresh_b_in;
  logic        centroid_valid_out;
  logic        found_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [19:0] pixel_count_out;
  logic        busy_out;

  modport master (
    output data_valid_in, pixel_data_in, hcount_in, vcount_in,
           thresh_r_in, thresh_g_in, thresh_b_in,
    input  centroid_valid_out, found_out, x_out, y_out, pixel_count_out, busy_out
  );

  modport slave (
    input  data_valid_in, pixel_data_in, hcount_in, vcount_in,
           thresh_r_in, thresh_g_in, thresh_b_in,
    output centroid_valid_out, found_out, x_out, y_out, pixel_count_out, busy_out
  );
endinterface

// File: rtl/centroid_tracker.sv
// Thresholds the RGB565 stream, accumulates bright-pixel coordinates per frame
// and serially divides the sums by the count to report the frame centroid.
module centroid_tracker #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int MIN_PIXELS = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  centroid_tracker_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, DONE} state_t;

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  state_t      state_reg, state_next;

  logic        in_range, bright, frame_end, start;
  logic [31:0] sum_x_reg, sum_y_reg;
  logic [19:0] cnt_reg;
  logic [31:0] sum_x_next, sum_y_next;
  logic [19:0] cnt_next;

  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] sum_y_snap_reg;
  logic [19:0] cnt_snap_reg;
  logic [10:0] quo_x_reg;
  logic [4:0]  iter_reg;

  logic [32:0] rem_shift;
  logic [32:0] divisor;
  logic        quo_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic        last_iter;
  logic        found_next;

  logic        valid_reg, found_reg;
  logic [10:0] x_reg;
  logic [9:0]  y_reg;
  logic [19:0] count_reg;

  assign in_range  = ({21'd0, bus.hcount_in} < 32'(H_ACTIVE)) &&
                     ({22'd0, bus.vcount_in} < 32'(V_ACTIVE));
  assign bright    = bus.data_valid_in && in_range &&
                     (bus.pixel_data_in[15:11] >= bus.thresh_r_in) &&
                     (bus.pixel_data_in[10:5]  >= bus.thresh_g_in) &&
                     (bus.pixel_data_in[4:0]   >= bus.thresh_b_in);
  assign frame_end = bus.data_valid_in && (bus.hcount_in == H_LAST) &&
                     (bus.vcount_in == V_LAST);
  // A frame end arriving while a division is in flight is not captured.
  assign start     = frame_end && (state_reg == ACCUM);

  assign sum_x_next = sum_x_reg + (bright ? {21'd0, bus.hcount_in} : 32'd0);
  assign sum_y_next = sum_y_reg + (bright ? {22'd0, bus.vcount_in} : 32'd0);
  assign cnt_next   = cnt_reg + (bright ? 20'd1 : 20'd0);

  always_ff @(posedge clk_in) begin
    if (rst_in || frame_end) begin
      sum_x_reg <= '0;
      sum_y_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      sum_x_reg <= sum_x_next;
      sum_y_reg <= sum_y_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Restoring division step: the dividend shifts out of quo_reg's MSB while
  // quotient bits shift into its LSB.
  assign rem_shift  = {rem_reg, quo_reg[31]};
  assign divisor    = {13'd0, cnt_snap_reg};
  assign quo_bit    = (rem_shift >= divisor);
  assign rem_next   = quo_bit ? 32'(rem_shift - divisor) : rem_shift[31:0];
  assign quo_next   = {quo_reg[30:0], quo_bit};
  assign last_iter  = (iter_reg == 5'd31);
  assign found_next = (cnt_snap_reg >= 20'(MIN_PIXELS));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (start) state_next = DIV_X;
      DIV_X:   if (last_iter) state_next = DIV_Y;
      DIV_Y:   if (last_iter) state_next = DONE;
      DONE:    state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_reg        <= '0;
      rem_reg        <= '0;
      sum_y_snap_reg <= '0;
      cnt_snap_reg   <= '0;
      quo_x_reg      <= '0;
      iter_reg       <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (start) begin
            quo_reg        <= sum_x_next;
            sum_y_snap_reg <= sum_y_next;
            cnt_snap_reg   <= cnt_next;
            rem_reg        <= '0;
            iter_reg       <= '0;
          end
        end
        DIV_X: begin
          iter_reg <= iter_reg + 5'd1;
          if (last_iter) begin
            quo_x_reg <= quo_next[10:0];
            quo_reg   <= sum_y_snap_reg;
            rem_reg   <= '0;
          end else begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
          end
        end
        DIV_Y: begin
          iter_reg <= iter_reg + 5'd1;
          quo_reg  <= quo_next;
          rem_reg  <= rem_next;
        end
        default: ;
      endcase
    end
  end

  // Coordinates only update on a valid detection; a low count keeps the last centroid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_reg <= 1'b0;
      found_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == DONE) begin
        valid_reg <= 1'b1;
        found_reg <= found_next;
        count_reg <= cnt_snap_reg;
        if (found_next) begin
          x_reg <= quo_x_reg;
          y_reg <= quo_reg[9:0];
        end
      end
    end
  end

  assign bus.centroid_valid_out = valid_reg;
  assign bus.found_out          = found_reg;
  assign bus.x_out              = x_reg;
  assign bus.y_out              = y_reg;
  assign bus.pixel_count_out    = count_reg;
  assign bus.busy_out           = (state_reg != ACCUM);
endmodule

// File: tb/tb_centroid_tracker.sv
// Drives sparse pixel frames into two trackers (MIN_PIXELS 1 and 4) and
// scoreboards every centroid result, including its exact arrival cycle.
module tb_centroid_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  centroid_tracker_if if1();
  centroid_tracker_if if4();

  centroid_tracker #(.H_ACTIVE(320), .V_ACTIVE(240), .MIN_PIXELS(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .bus(if1)
  );
  centroid_tracker #(.H_ACTIVE(320), .V_ACTIVE(240), .MIN_PIXELS(4)) u_dut4 (
    .clk_in(clk), .rst_in(rst), .bus(if4)
  );

  assign if4.data_valid_in = if1.data_valid_in;
  assign if4.pixel_data_in = if1.pixel_data_in;
  assign if4.hcount_in     = if1.hcount_in;
  assign if4.vcount_in     = if1.vcount_in;
  assign if4.thresh_r_in   = if1.thresh_r_in;
  assign if4.thresh_g_in   = if1.thresh_g_in;
  assign if4.thresh_b_in   = if1.thresh_b_in;

  typedef struct {
    int          cyc;
    logic        found;
    logic [10:0] x;
    logic [9:0]  y;
    logic [19:0] cnt;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] pix;
  } px_t;

  typedef struct {
    int   first;
    int   num;
    exp_t e1;
    exp_t e4;
  } frame_t;

  exp_t   q1[$];
  exp_t   q4[$];
  px_t    px_tab[$];
  frame_t frames[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic f,
                       input logic [10:0] x, input logic [9:0] y, input logic [19:0] c);
    check({tag, "_latency"}, 32'(cyc), 32'(e.cyc));
    check({tag, "_found"}, 32'(f), 32'(e.found));
    check({tag, "_x"}, 32'(x), 32'(e.x));
    check({tag, "_y"}, 32'(y), 32'(e.y));
    check({tag, "_count"}, 32'(c), 32'(e.cnt));
    $display("result %s cycle=%0d found=%0b x=%0d y=%0d count=%0d", tag, cyc, f, x, y, c);
  endtask

  always @(negedge clk) begin
    if (if1.centroid_valid_out === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_valid: got pulse at cycle %0d required none", cyc);
      end else begin
        score("dut1", q1.pop_front(), if1.found_out, if1.x_out, if1.y_out, if1.pixel_count_out);
      end
    end
    if (if4.centroid_valid_out === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_valid: got pulse at cycle %0d required none", cyc);
      end else begin
        score("dut4", q4.pop_front(), if4.found_out, if4.x_out, if4.y_out, if4.pixel_count_out);
      end
    end
  end

  function automatic exp_t mk(input logic f, input int x, input int y, input int c);
    exp_t e;
    e.cyc = 0; e.found = f; e.x = 11'(x); e.y = 10'(y); e.cnt = 20'(c);
    return e;
  endfunction

  task automatic add_px(input logic v, input int h, input int vv, input logic [15:0] p);
    px_t t;
    t.valid = v; t.h = 11'(h); t.v = 10'(vv); t.pix = p;
    px_tab.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [10:0] h, input logic [9:0] vv, input logic [15:0] p);
    @(negedge clk);
    if1.data_valid_in = v;
    if1.hcount_in     = h;
    if1.vcount_in     = vv;
    if1.pixel_data_in = p;
    @(posedge clk);
    #1;
    if1.data_valid_in = 1'b0;
  endtask

  // Frame-end pixel whose snapshot must be accepted; queues both expectations.
  task automatic frame_end(input logic [15:0] p, input exp_t e1, input exp_t e4);
    exp_t a, b;
    drive(1'b1, 11'd319, 10'd239, p);
    a = e1; b = e4;
    a.cyc = cyc + 65;
    b.cyc = cyc + 65;
    q1.push_back(a);
    q4.push_back(b);
    $display("frame end at cycle %0d: expect dut1 (%0d,%0d) n=%0d, dut4 found=%0b", cyc, a.x, a.y, a.cnt, b.found);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rst_valid"}, 32'(if1.centroid_valid_out), 32'd0);
    check({tag, "_rst_found"}, 32'(if1.found_out), 32'd0);
    check({tag, "_rst_x"}, 32'(if1.x_out), 32'd0);
    check({tag, "_rst_y"}, 32'(if1.y_out), 32'd0);
    check({tag, "_rst_count"}, 32'(if1.pixel_count_out), 32'd0);
    check({tag, "_rst_busy"}, 32'(if1.busy_out), 32'd0);
    check({tag, "_rst_valid4"}, 32'(if4.centroid_valid_out), 32'd0);
    check({tag, "_rst_found4"}, 32'(if4.found_out), 32'd0);
    check({tag, "_rst_x4"}, 32'(if4.x_out), 32'd0);
    check({tag, "_rst_y4"}, 32'(if4.y_out), 32'd0);
    check({tag, "_rst_count4"}, 32'(if4.pixel_count_out), 32'd0);
    check({tag, "_rst_busy4"}, 32'(if4.busy_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    if1.data_valid_in = 1'b0;
    if1.pixel_data_in = 16'h0000;
    if1.hcount_in     = 11'd0;
    if1.vcount_in     = 10'd0;
    if1.thresh_r_in   = 5'd20;
    if1.thresh_g_in   = 6'd40;
    if1.thresh_b_in   = 5'd20;

    // A: single bright pixel at (100,50)
    frames[0].first = px_tab.size();
    add_px(1, 100, 50, 16'hFFFF); add_px(1, 101, 50, 16'h0000); add_px(1, 5, 5, 16'h0000);
    frames[0].num = px_tab.size() - frames[0].first;
    frames[0].e1 = mk(1, 100, 50, 1);
    frames[0].e4 = mk(0, 0, 0, 1);
    // B: 3x3 block plus single-channel and out-of-range distractors
    frames[1].first = px_tab.size();
    for (int yy = 20; yy <= 22; yy++)
      for (int xx = 10; xx <= 12; xx++)
        add_px(1, xx, yy, 16'hFFFF);
    add_px(1, 50, 60, 16'h07E0); add_px(1, 51, 60, 16'hF800); add_px(1, 52, 60, 16'h001F);
    add_px(1, 320, 10, 16'hFFFF); add_px(1, 10, 240, 16'hFFFF); add_px(0, 11, 21, 16'hFFFF);
    add_px(1, 319, 240, 16'hFFFF);
    frames[1].num = px_tab.size() - frames[1].first;
    frames[1].e1 = mk(1, 11, 21, 9);
    frames[1].e4 = mk(1, 11, 21, 9);
    // C: floor of mean
    frames[2].first = px_tab.size();
    add_px(1, 0, 0, 16'hFFFF); add_px(1, 5, 0, 16'hFFFF);
    frames[2].num = px_tab.size() - frames[2].first;
    frames[2].e1 = mk(1, 2, 0, 2);
    frames[2].e4 = mk(0, 11, 21, 2);
    // D1: four pixels centred on (100,50)
    frames[3].first = px_tab.size();
    add_px(1, 99, 49, 16'hFFFF); add_px(1, 101, 49, 16'hFFFF);
    add_px(1, 99, 51, 16'hFFFF); add_px(1, 101, 51, 16'hFFFF);
    frames[3].num = px_tab.size() - frames[3].first;
    frames[3].e1 = mk(1, 100, 50, 4);
    frames[3].e4 = mk(1, 100, 50, 4);
    // D2: three pixels, below MIN_PIXELS=4
    frames[4].first = px_tab.size();
    add_px(1, 1, 1, 16'hFFFF); add_px(1, 2, 2, 16'hFFFF); add_px(1, 3, 3, 16'hFFFF);
    frames[4].num = px_tab.size() - frames[4].first;
    frames[4].e1 = mk(1, 2, 2, 3);
    frames[4].e4 = mk(0, 100, 50, 3);
    // E: threshold equality counts, one below on any channel does not
    frames[5].first = px_tab.size();
    add_px(1, 30, 40, 16'hA514); add_px(1, 60, 40, 16'h9D14);
    add_px(1, 61, 40, 16'hA4F4); add_px(1, 62, 40, 16'hA513);
    frames[5].num = px_tab.size() - frames[5].first;
    frames[5].e1 = mk(1, 30, 40, 1);
    frames[5].e4 = mk(0, 100, 50, 1);

    idle(3);
    rst = 1'b0;
    idle(1);
    check_zero("init");

    for (int f = 0; f < 6; f++) begin
      for (int i = frames[f].first; i < frames[f].first + frames[f].num; i++)
        drive(px_tab[i].valid, px_tab[i].h, px_tab[i].v, px_tab[i].pix);
      frame_end(16'h0000, frames[f].e1, frames[f].e4);
      @(posedge clk); #1;
      check("busy_during_div", 32'(if1.busy_out), 32'd1);
      idle(70);
      check("busy_after_done", 32'(if1.busy_out), 32'd0);
    end

    // Frame end while busy: snapshot dropped, accumulators still cleared
    drive(1'b1, 11'd40, 10'd44, 16'hFFFF);
    frame_end(16'h0000, mk(1, 40, 44, 1), mk(0, 100, 50, 1));
    idle(5);
    drive(1'b1, 11'd50, 10'd50, 16'hFFFF);
    drive(1'b1, 11'd319, 10'd239, 16'h0000);
    idle(70);
    drive(1'b1, 11'd20, 10'd30, 16'hFFFF);
    frame_end(16'h0000, mk(1, 20, 30, 1), mk(0, 100, 50, 1));
    idle(70);

    // Back-to-back frames with a bright frame-end pixel and a bright pixel right after
    drive(1'b1, 11'd318, 10'd239, 16'h0000);
    frame_end(16'hFFFF, mk(1, 319, 239, 1), mk(0, 100, 50, 1));
    drive(1'b1, 11'd0, 10'd0, 16'hFFFF);
    drive(1'b1, 11'd1, 10'd0, 16'h0000);
    idle(70);
    frame_end(16'h0000, mk(1, 0, 0, 1), mk(0, 100, 50, 1));
    idle(70);

    // Reset during DIV_Y aborts the division without a result
    drive(1'b1, 11'd200, 10'd100, 16'hFFFF);
    drive(1'b1, 11'd319, 10'd239, 16'h0000);
    idle(40);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_zero("mid_div");
    idle(80);
    drive(1'b1, 11'd7, 10'd9, 16'hFFFF);
    frame_end(16'h0000, mk(1, 7, 9, 1), mk(0, 0, 0, 1));
    idle(70);

    check("dut1_pending_results", 32'(q1.size()), 32'd0);
    check("dut4_pending_results", 32'(q4.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
